// File: rtl/mem_bus_interface.sv
// mem_bus_interface: bridges the 16-bit datapath to the external memory bus.
// Ports: Clock/Reset; MemRead/MemWrite/Address/WriteData request side;
//        DataIn/MemReady/BusError datapath return;
//        ExtAddr/ExtDataOut/ExtDataOutEn/nOE/nWE/ExtDataIn/ExtReady bus pins.
module mem_bus_interface #(
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    output logic [15:0] DataIn,
    output logic        MemReady,
    output logic        BusError,
    output logic [15:0] ExtAddr,
    output logic [15:0] ExtDataOut,
    output logic        ExtDataOutEn,
    output logic        nOE,
    output logic        nWE,
    input  logic [15:0] ExtDataIn,
    input  logic        ExtReady
);

    localparam logic [7:0] WAIT_C = 8'(WAIT_CYCLES);
    localparam logic [7:0] TMO_C  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic [15:0] addr_nx, dout_nx, din_nx;
    logic        doen_nx, noe_nx, nwe_nx, rdy_nx, err_nx;
    logic        finish, expired;

    // ExtReady only counts once the minimum wait has elapsed, and it
    // takes priority over a timeout reached at the same edge.
    assign finish  = (wait_cnt >= WAIT_C) && ExtReady;
    assign expired = (wait_cnt == TMO_C);

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        addr_nx     = ExtAddr;
        dout_nx     = ExtDataOut;
        din_nx      = DataIn;
        doen_nx     = ExtDataOutEn;
        noe_nx      = 1'b1;
        nwe_nx      = 1'b1;
        rdy_nx      = 1'b0;
        err_nx      = 1'b0;
        unique case (state)
            IDLE: begin
                doen_nx = 1'b0;
                if (MemRead && MemWrite) begin
                    err_nx = 1'b1;
                end else if (MemRead) begin
                    addr_nx     = Address;
                    wait_cnt_nx = 8'd0;
                    noe_nx      = 1'b0;
                    state_nx    = READ;
                end else if (MemWrite) begin
                    addr_nx     = Address;
                    dout_nx     = WriteData;
                    doen_nx     = 1'b1;
                    wait_cnt_nx = 8'd0;
                    nwe_nx      = 1'b0;
                    state_nx    = WRITE;
                end
            end
            READ: begin
                wait_cnt_nx = wait_cnt + 8'd1;
                if (finish) begin
                    din_nx   = ExtDataIn;
                    rdy_nx   = 1'b1;
                    state_nx = DONE;
                end else if (expired) begin
                    rdy_nx   = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    noe_nx = 1'b0;
                end
            end
            WRITE: begin
                wait_cnt_nx = wait_cnt + 8'd1;
                if (finish) begin
                    rdy_nx   = 1'b1;
                    state_nx = DONE;
                end else if (expired) begin
                    rdy_nx   = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    nwe_nx = 1'b0;
                end
            end
            DONE: begin
                // Address/data were held through DONE for hold time;
                // the pad driver is released as we return to IDLE.
                doen_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            ExtAddr      <= 16'd0;
            ExtDataOut   <= 16'd0;
            ExtDataOutEn <= 1'b0;
            DataIn       <= 16'd0;
            nOE          <= 1'b1;
            nWE          <= 1'b1;
            MemReady     <= 1'b0;
            BusError     <= 1'b0;
        end else begin
            state        <= state_nx;
            wait_cnt     <= wait_cnt_nx;
            ExtAddr      <= addr_nx;
            ExtDataOut   <= dout_nx;
            ExtDataOutEn <= doen_nx;
            DataIn       <= din_nx;
            nOE          <= noe_nx;
            nWE          <= nwe_nx;
            MemReady     <= rdy_nx;
            BusError     <= err_nx;
        end
    end

endmodule
